// File: rtl/unaligned_lsu.sv
// Load/store alignment unit: turns one LSU operation into one or two aligned
// bus beats and merges the returned bytes into the register value.
module unaligned_lsu #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int SPLIT_EN = 0
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [2:0]          req_op,
   input  logic [1:0]          req_size,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_rt,
   output logic                bus_req_valid,
   input  logic                bus_req_ready,
   output logic                bus_wr,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W/8-1:0] bus_wstrb,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic                bus_resp_valid,
   input  logic [DATA_W-1:0]   bus_rdata,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_data,
   output logic [DATA_W/8-1:0] resp_be,
   output logic                resp_err
);
   // state | meaning
   // IDLE  | waiting for a request
   // REQ1  | first (or only) beat offered on the bus
   // WAIT1 | waiting for first beat response
   // REQ2  | second beat of a split access offered
   // WAIT2 | waiting for second beat response
   // RESP  | result held until resp_ready
   localparam int NB = DATA_W / 8;
   localparam int OB = $clog2(NB);
   localparam logic [NB-1:0] ONES = '1;
   localparam logic [2:0] OP_LOAD_S = 3'd0, OP_LOAD_U = 3'd1, OP_LOAD_RIGHT = 3'd3,
                          OP_STORE = 3'd4, OP_STORE_LEFT = 3'd5, OP_STORE_RIGHT = 3'd6,
                          OP_LOAD_LEFT = 3'd2, OP_ILL = 3'd7;

   typedef enum logic [2:0] {S_IDLE, S_REQ1, S_WAIT1, S_REQ2, S_WAIT2, S_RESP} state_t;

   state_t              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [1:0]          size_q, size_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   rt_q, rt_d, rdata1_q, rdata1_d;
   logic                req_ready_q, req_ready_d, bus_req_valid_q, bus_req_valid_d;
   logic                bus_wr_q, bus_wr_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
   logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
   logic [NB-1:0]       bus_wstrb_q, bus_wstrb_d, resp_be_q, resp_be_d;
   logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d, resp_data_q, resp_data_d;

   logic [2:0]          cur_op;
   logic [1:0]          cur_size;
   logic [ADDR_W-1:0]   cur_addr, base_addr;
   logic [DATA_W-1:0]   cur_rt, rd_lo, rd_hi, merged, ext, ld_val, ld_data, bemask;
   logic [2*NB-1:0]     strb2;
   logic [2*DATA_W-1:0] wdata2;
   logic [NB-1:0]       ld_be;
   logic                is_plain, is_load, is_left, is_right, req_err, split, sign_bit;
   int                  off_i, n_i;

   // In IDLE the request is decoded straight from the inputs; afterwards from the latched copy.
   always_comb begin
      cur_op    = (state_q == S_IDLE) ? req_op   : op_q;
      cur_size  = (state_q == S_IDLE) ? req_size : size_q;
      cur_addr  = (state_q == S_IDLE) ? req_addr : addr_q;
      cur_rt    = (state_q == S_IDLE) ? req_rt   : rt_q;
      off_i     = int'(cur_addr[OB-1:0]);
      n_i       = 1 << cur_size;
      is_plain  = (cur_op == OP_LOAD_S) || (cur_op == OP_LOAD_U) || (cur_op == OP_STORE);
      is_load   = (cur_op <= OP_LOAD_RIGHT);
      is_left   = (cur_op == OP_LOAD_LEFT) || (cur_op == OP_STORE_LEFT);
      is_right  = (cur_op == OP_LOAD_RIGHT) || (cur_op == OP_STORE_RIGHT);
      req_err   = (cur_op == OP_ILL) || (is_plain && n_i > NB) ||
                  (SPLIT_EN == 0 && is_plain && (off_i & (n_i - 1)) != 0);
      split     = (SPLIT_EN != 0) && is_plain && (off_i + n_i > NB);
      base_addr = {cur_addr[ADDR_W-1:OB], {OB{1'b0}}};

      if (is_left)
         strb2 = {{NB{1'b0}}, ONES >> (NB - 1 - off_i)};
      else if (is_right)
         strb2 = {{NB{1'b0}}, ONES << off_i};
      else
         strb2 = (~({2*NB{1'b1}} << n_i)) << off_i;
      if (is_left)
         wdata2 = {{DATA_W{1'b0}}, cur_rt >> (8 * (NB - 1 - off_i))};
      else
         wdata2 = {{DATA_W{1'b0}}, cur_rt} << (8 * off_i);

      rd_lo    = (state_q == S_WAIT2) ? rdata1_q  : bus_rdata;
      rd_hi    = (state_q == S_WAIT2) ? bus_rdata : '0;
      merged   = (rd_lo >> (8 * off_i)) | (rd_hi << (8 * (NB - off_i)));
      sign_bit = 1'b0;
      for (int b = 0; b < NB; b++)
         if (b == n_i - 1) sign_bit = merged[8*b+7];
      ext = '0;
      for (int b = 0; b < NB; b++)
         ext[8*b +: 8] = (b < n_i) ? merged[8*b +: 8] : {8{sign_bit & (cur_op == OP_LOAD_S)}};

      if (cur_op == OP_LOAD_LEFT) begin
         ld_val = rd_lo << (8 * (NB - 1 - off_i));
         ld_be  = ONES << (NB - 1 - off_i);
      end else if (cur_op == OP_LOAD_RIGHT) begin
         ld_val = rd_lo >> (8 * off_i);
         ld_be  = ONES >> off_i;
      end else if (is_load) begin
         ld_val = ext;
         ld_be  = ONES;
      end else begin
         ld_val = '0;
         ld_be  = '0;
      end
      bemask = '0;
      for (int b = 0; b < NB; b++) bemask[8*b +: 8] = {8{ld_be[b]}};
      ld_data = is_load ? ((ld_val & bemask) | (cur_rt & ~bemask)) : '0;
   end

   always_comb begin
      state_d         = state_q;
      op_d            = op_q;
      size_d          = size_q;
      addr_d          = addr_q;
      rt_d            = rt_q;
      rdata1_d        = rdata1_q;
      bus_req_valid_d = bus_req_valid_q;
      bus_wr_d        = bus_wr_q;
      bus_addr_d      = bus_addr_q;
      bus_wstrb_d     = bus_wstrb_q;
      bus_wdata_d     = bus_wdata_q;
      resp_valid_d    = resp_valid_q;
      resp_data_d     = resp_data_q;
      resp_be_d       = resp_be_q;
      resp_err_d      = resp_err_q;
      case (state_q)
         S_IDLE: if (req_valid && req_ready_q) begin
            op_d   = req_op;
            size_d = req_size;
            addr_d = req_addr;
            rt_d   = req_rt;
            if (req_err) begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               resp_be_d    = '0;
               resp_data_d  = '0;
            end else begin
               state_d         = S_REQ1;
               bus_req_valid_d = 1'b1;
               bus_wr_d        = !is_load;
               bus_addr_d      = base_addr;
               bus_wstrb_d     = strb2[NB-1:0];
               bus_wdata_d     = wdata2[DATA_W-1:0];
            end
         end
         S_REQ1: if (bus_req_ready) begin
            bus_req_valid_d = 1'b0;
            state_d         = S_WAIT1;
         end
         S_WAIT1: if (bus_resp_valid) begin
            if (split) begin
               rdata1_d        = bus_rdata;
               state_d         = S_REQ2;
               bus_req_valid_d = 1'b1;
               bus_addr_d      = base_addr + ADDR_W'(NB);
               bus_wstrb_d     = strb2[2*NB-1:NB];
               bus_wdata_d     = wdata2[2*DATA_W-1:DATA_W];
            end else begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_be_d    = ld_be;
               resp_data_d  = ld_data;
            end
         end
         S_REQ2: if (bus_req_ready) begin
            bus_req_valid_d = 1'b0;
            state_d         = S_WAIT2;
         end
         S_WAIT2: if (bus_resp_valid) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_be_d    = ld_be;
            resp_data_d  = ld_data;
         end
         S_RESP: if (resp_ready) begin
            resp_valid_d = 1'b0;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      req_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q         <= S_IDLE;
         op_q            <= '0;
         size_q          <= '0;
         addr_q          <= '0;
         rt_q            <= '0;
         rdata1_q        <= '0;
         req_ready_q     <= 1'b0;
         bus_req_valid_q <= 1'b0;
         bus_wr_q        <= 1'b0;
         bus_addr_q      <= '0;
         bus_wstrb_q     <= '0;
         bus_wdata_q     <= '0;
         resp_valid_q    <= 1'b0;
         resp_data_q     <= '0;
         resp_be_q       <= '0;
         resp_err_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         op_q            <= op_d;
         size_q          <= size_d;
         addr_q          <= addr_d;
         rt_q            <= rt_d;
         rdata1_q        <= rdata1_d;
         req_ready_q     <= req_ready_d;
         bus_req_valid_q <= bus_req_valid_d;
         bus_wr_q        <= bus_wr_d;
         bus_addr_q      <= bus_addr_d;
         bus_wstrb_q     <= bus_wstrb_d;
         bus_wdata_q     <= bus_wdata_d;
         resp_valid_q    <= resp_valid_d;
         resp_data_q     <= resp_data_d;
         resp_be_q       <= resp_be_d;
         resp_err_q      <= resp_err_d;
      end
   end

   assign req_ready     = req_ready_q;
   assign bus_req_valid = bus_req_valid_q;
   assign bus_wr        = bus_wr_q;
   assign bus_addr      = bus_addr_q;
   assign bus_wstrb     = bus_wstrb_q;
   assign bus_wdata     = bus_wdata_q;
   assign resp_valid    = resp_valid_q;
   assign resp_data     = resp_data_q;
   assign resp_be       = resp_be_q;
   assign resp_err      = resp_err_q;
endmodule

// File: tb/tb_unaligned_lsu.sv
// Bench for unaligned_lsu: instance 0 has splitting disabled, instance 1 enabled.
// A byte-level memory model predicts beats, strobes, lanes and register results.
module tb_unaligned_lsu;
   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid[2], req_ready[2], bus_req_valid[2], bus_req_ready[2], bus_wr[2];
   logic        bus_resp_valid[2], resp_valid[2], resp_ready[2], resp_err[2];
   logic [2:0]  req_op[2];
   logic [1:0]  req_size[2];
   logic [31:0] req_addr[2], req_rt[2], bus_addr[2], bus_wdata[2], bus_rdata[2], resp_data[2];
   logic [3:0]  bus_wstrb[2], resp_be[2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      unaligned_lsu #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(g)) dut (
         .clk(clk), .resetn(resetn),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_op(req_op[g]),
         .req_size(req_size[g]), .req_addr(req_addr[g]), .req_rt(req_rt[g]),
         .bus_req_valid(bus_req_valid[g]), .bus_req_ready(bus_req_ready[g]),
         .bus_wr(bus_wr[g]), .bus_addr(bus_addr[g]), .bus_wstrb(bus_wstrb[g]),
         .bus_wdata(bus_wdata[g]), .bus_resp_valid(bus_resp_valid[g]), .bus_rdata(bus_rdata[g]),
         .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]), .resp_data(resp_data[g]),
         .resp_be(resp_be[g]), .resp_err(resp_err[g]));
   end

   int checks = 0, failures = 0;
   logic [7:0] mem [int];

   // model outputs
   bit          e_err, e_wr;
   int          e_nbeats, e_lat;
   logic [3:0]  e_strb[2], e_be;
   logic [7:0]  e_lane[2][4];
   logic [31:0] e_addr[2], e_data;
   // captured DUT values for hand-computed pins
   logic [31:0] got_data, got_wdata0;
   logic [3:0]  got_be, got_strb[2];
   logic        got_err;

   task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] mem_rd(int a);
      return mem.exists(a) ? mem[a] : 8'(a * 29 + 7);
   endfunction

   task automatic mem_wr32(int a, logic [31:0] w);
      for (int j = 0; j < 4; j++) mem[a + j] = w[8*j +: 8];
   endtask

   function automatic bit out_zero(int u);
      return !req_ready[u] && !bus_req_valid[u] && !bus_wr[u] && bus_addr[u] == 0 &&
             bus_wstrb[u] == 0 && bus_wdata[u] == 0 && !resp_valid[u] && resp_data[u] == 0 &&
             resp_be[u] == 0 && !resp_err[u];
   endfunction

   // Each op touches a list of (memory byte address, register byte index) pairs.
   task automatic model(int u, logic [2:0] op, logic [1:0] size, logic [31:0] addr, logic [31:0] rt);
      int o, n, cnt, a0, bt, ln;
      int acc_a[8], acc_r[8];
      bit plain;
      o = int'(addr % 4); n = 1 << size; a0 = int'(addr) - o;
      plain = (op == 0 || op == 1 || op == 4);
      e_err = (op == 7) || (plain && n > 4) || (u == 0 && plain && (o % n) != 0);
      e_wr = (op >= 4);
      e_strb[0] = 0; e_strb[1] = 0; e_be = 0; e_data = 0; e_nbeats = 0;
      for (int b = 0; b < 2; b++) for (int j = 0; j < 4; j++) e_lane[b][j] = 0;
      e_addr[0] = 32'(a0); e_addr[1] = 32'(a0 + 4);
      e_lat = 1;
      if (e_err) return;
      if (plain) begin
         cnt = n;
         for (int i = 0; i < cnt; i++) begin acc_a[i] = int'(addr) + i; acc_r[i] = i; end
      end else if (op == 2 || op == 5) begin
         cnt = o + 1;
         for (int i = 0; i < cnt; i++) begin acc_a[i] = a0 + i; acc_r[i] = 3 - o + i; end
      end else begin
         cnt = 4 - o;
         for (int i = 0; i < cnt; i++) begin acc_a[i] = a0 + o + i; acc_r[i] = i; end
      end
      if (!e_wr && !plain) e_data = rt;
      for (int i = 0; i < cnt; i++) begin
         bt = (acc_a[i] - a0) / 4; ln = (acc_a[i] - a0) % 4;
         e_strb[bt][ln] = 1'b1;
         if (bt + 1 > e_nbeats) e_nbeats = bt + 1;
         if (e_wr) e_lane[bt][ln] = rt[8*acc_r[i] +: 8];
         else begin
            e_data[8*acc_r[i] +: 8] = mem_rd(acc_a[i]);
            e_be[acc_r[i]] = 1'b1;
         end
      end
      if (!e_wr && plain) begin
         e_be = 4'hF;
         for (int b = n; b < 4; b++)
            e_data[8*b +: 8] = (op == 0 && e_data[8*n-1]) ? 8'hFF : 8'h00;
      end
      e_lat = 1 + 2 * e_nbeats;
   endtask

   task automatic run(int u, logic [2:0] op, logic [1:0] size, logic [31:0] addr,
                      logic [31:0] rt, int bstall, int rstall);
      int cyc, beat, bw, rw;
      bit pend, done, seen_b, seen_r;
      logic [31:0] hs_addr, s_addr, s_wdata, s_data, w;
      logic [3:0]  s_strb, s_be;
      logic        s_wr, s_err;
      model(u, op, size, addr, rt);
      @(negedge clk);
      chk("req_ready_idle", req_ready[u], 1);
      req_valid[u] = 1; req_op[u] = op; req_size[u] = size; req_addr[u] = addr; req_rt[u] = rt;
      bus_resp_valid[u] = 1; bus_rdata[u] = 32'hDEADBEEF;
      @(negedge clk);
      req_valid[u] = 0; bus_resp_valid[u] = 0;
      req_op[u] = 3'($urandom); req_size[u] = 2'($urandom); req_addr[u] = $urandom; req_rt[u] = $urandom;
      cyc = 1; beat = 0; bw = bstall; rw = rstall; pend = 0; done = 0; seen_b = 0; seen_r = 0;
      while (!done && cyc < 100) begin
         bus_resp_valid[u] = 0;
         if (pend) begin
            for (int j = 0; j < 4; j++) w[8*j +: 8] = mem_rd(int'(hs_addr) + j);
            bus_resp_valid[u] = 1; bus_rdata[u] = w; pend = 0;
         end
         chk("req_ready_busy", req_ready[u], 0);
         if (bus_req_valid[u]) begin
            if (!seen_b) begin
               seen_b = 1;
               s_addr = bus_addr[u]; s_strb = bus_wstrb[u]; s_wdata = bus_wdata[u]; s_wr = bus_wr[u];
               chk("beat_expected", beat < e_nbeats, 1);
               if (beat < e_nbeats) begin
                  got_strb[beat] = bus_wstrb[u];
                  if (beat == 0) got_wdata0 = bus_wdata[u];
                  chk("bus_addr", bus_addr[u], e_addr[beat]);
                  chk("bus_wr", bus_wr[u], e_wr);
                  chk("bus_wstrb", bus_wstrb[u], e_strb[beat]);
                  if (e_wr)
                     for (int j = 0; j < 4; j++)
                        if (e_strb[beat][j]) chk("bus_wdata_lane", bus_wdata[u][8*j +: 8], e_lane[beat][j]);
               end
            end else
               chk("bus_stable", bus_addr[u] == s_addr && bus_wstrb[u] == s_strb &&
                                 bus_wdata[u] == s_wdata && bus_wr[u] == s_wr, 1);
            if (bw > 0) begin
               bus_req_ready[u] = 0; bw--;
            end else begin
               bus_req_ready[u] = 1; hs_addr = bus_addr[u]; pend = 1;
               if (bus_wr[u])
                  for (int j = 0; j < 4; j++)
                     if (bus_wstrb[u][j]) mem[int'(bus_addr[u]) + j] = bus_wdata[u][8*j +: 8];
               beat++; bw = bstall; seen_b = 0;
            end
         end else bus_req_ready[u] = 0;
         if (resp_valid[u]) begin
            if (!seen_r) begin
               seen_r = 1;
               s_data = resp_data[u]; s_be = resp_be[u]; s_err = resp_err[u];
               got_data = resp_data[u]; got_be = resp_be[u]; got_err = resp_err[u];
               if (bstall == 0 && rstall == 0) chk("resp_latency", cyc, e_lat);
               chk("resp_err", resp_err[u], e_err);
               chk("resp_be", resp_be[u], e_be);
               if (!e_err && !e_wr) chk("resp_data", resp_data[u], e_data);
            end else
               chk("resp_stable", resp_data[u] == s_data && resp_be[u] == s_be && resp_err[u] == s_err, 1);
            if (rw > 0) begin resp_ready[u] = 0; rw--; end
            else begin resp_ready[u] = 1; done = 1; end
         end else resp_ready[u] = 0;
         @(negedge clk);
         cyc++;
      end
      resp_ready[u] = 0; bus_req_ready[u] = 0; bus_resp_valid[u] = 0;
      chk("done_in_time", done, 1);
      chk("beats_issued", beat, e_nbeats);
      chk("resp_dropped", resp_valid[u], 0);
      chk("bus_idle_after", bus_req_valid[u], 0);
      chk("ready_after", req_ready[u], 1);
   endtask

   initial begin
      resetn = 0;
      for (int u = 0; u < 2; u++) begin
         req_valid[u] = 0; req_op[u] = 0; req_size[u] = 0; req_addr[u] = 0; req_rt[u] = 0;
         bus_req_ready[u] = 0; bus_resp_valid[u] = 0; bus_rdata[u] = 0; resp_ready[u] = 0;
      end
      repeat (3) @(negedge clk);
      chk("reset_zero_u0", out_zero(0), 1);
      chk("reset_zero_u1", out_zero(1), 1);
      resetn = 1;
      @(negedge clk);
      chk("ready_after_reset_u0", req_ready[0], 1);
      chk("ready_after_reset_u1", req_ready[1], 1);

      mem_wr32(32'h1000, 32'h44332211);
      run(0, 3'd2, 2'd0, 32'h1001, 32'hAABBCCDD, 0, 0);
      chk("tp_lwl_data", got_data, 32'h2211CCDD);
      chk("tp_lwl_be", got_be, 4'b1100);

      run(0, 3'd6, 2'd0, 32'h2003, 32'h12345678, 0, 0);
      chk("tp_swr_strb", got_strb[0], 4'b1000);
      chk("tp_swr_lane3", got_wdata0[31:24], 8'h78);

      mem_wr32(0, 32'h80FFFFFF);
      mem_wr32(4, 32'h000000FF);
      run(1, 3'd0, 2'd2, 32'h0003, 32'h0, 0, 0);
      chk("tp_split_strb1", got_strb[0], 4'b1000);
      chk("tp_split_strb2", got_strb[1], 4'b0111);
      chk("tp_split_data", got_data, 32'h0000FF80);

      run(0, 3'd4, 2'd1, 32'h0001, 32'hCAFEF00D, 0, 0);
      chk("tp_misalign_err", got_err, 1);

      run(1, 3'd4, 2'd2, 32'h0021, 32'hA1B2C3D4, 5, 3);
      run(1, 3'd1, 2'd2, 32'h0021, 32'h0, 0, 0);
      chk("tp_stall_readback", got_data, 32'hA1B2C3D4);

      // reset while the second beat of a split load is outstanding
      @(negedge clk);
      req_valid[1] = 1; req_op[1] = 3'd0; req_size[1] = 2'd2; req_addr[1] = 32'h3; req_rt[1] = 0;
      @(negedge clk);
      req_valid[1] = 0; bus_req_ready[1] = 1;
      @(negedge clk);
      bus_req_ready[1] = 0; bus_resp_valid[1] = 1; bus_rdata[1] = 32'h80FFFFFF;
      @(negedge clk);
      bus_resp_valid[1] = 0;
      chk("rst_seq_req2", bus_req_valid[1], 1);
      bus_req_ready[1] = 1;
      @(negedge clk);
      bus_req_ready[1] = 0;
      chk("rst_seq_wait2", bus_req_valid[1] == 0 && resp_valid[1] == 0, 1);
      resetn = 0;
      @(negedge clk);
      chk("rst_mid_zero", out_zero(1), 1);
      resetn = 1;
      @(negedge clk);
      chk("rst_mid_ready", req_ready[1], 1);
      mem[32'h15] = 8'h9C;
      run(1, 3'd1, 2'd0, 32'h0015, 32'h0, 0, 0);
      chk("rst_then_lbu", got_data, 32'h0000009C);

      for (int i = 0; i < 300; i++) begin
         int u, bs, rs;
         u  = int'($urandom % 2);
         bs = ($urandom % 4 == 0) ? int'($urandom % 3) : 0;
         rs = ($urandom % 4 == 0) ? int'($urandom % 3) : 0;
         run(u, 3'($urandom % 8), 2'($urandom % 4), $urandom % 64, $urandom, bs, rs);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
